// File: rtl/rriot_bus_ctrl.sv
// rriot_bus_ctrl -- bus sequencer between a phi2-timed CPU bus and the
// ROM / RAM / IO sub-units of an RRIOT-style device.
//
// Each CPU cycle opens on a phi2 rise. The address, direction and target are
// latched on that rise. The controller then steps through ADDR and FETCH
// into DATA for reads or WRITE for writes, and finishes on the phi2 fall.
// A phi2 fall seen during ADDR or FETCH ends the cycle early. In that case
// the cycle drives no data and strobes no write.
//
// Build option:
//   RRIOT_BUS_HOLD_EN -- when defined, dout keeps the last value driven
//                        during DATA while doe is low. When undefined, dout
//                        reads 8'h00 whenever doe is low.
module rriot_bus_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phi2,
  input  logic       cs,
  input  logic       rs0_n,
  input  logic [9:0] a,
  input  logic       rw,
  input  logic [7:0] di,
  output logic       rom_en,
  output logic [9:0] rom_a,
  output logic       ram_en,
  output logic       ram_we,
  output logic [5:0] ram_a,
  output logic [7:0] ram_di,
  output logic       io_en,
  output logic       io_we,
  output logic [3:0] io_a,
  output logic [7:0] io_di,
  input  logic       rom_oe,
  input  logic       ram_oe,
  input  logic       io_oe,
  input  logic [7:0] rom_do,
  input  logic [7:0] ram_do,
  input  logic [7:0] io_do,
  output logic [7:0] dout,
  output logic       doe
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  localparam logic [1:0] TGT_NONE = 2'd0;
  localparam logic [1:0] TGT_ROM  = 2'd1;
  localparam logic [1:0] TGT_RAM  = 2'd2;
  localparam logic [1:0] TGT_IO   = 2'd3;

  // Chooses the addressed sub-unit. ROM select wins over the combined chip
  // select, and a[6] splits the chip-select window into RAM and IO.
  function automatic logic [1:0] decode_target(input logic rs0_n_v,
                                               input logic cs_v,
                                               input logic a6_v);
    logic [1:0] t;
    if (!rs0_n_v) begin
      t = TGT_ROM;
    end else if (cs_v) begin
      t = a6_v ? TGT_IO : TGT_RAM;
    end else begin
      t = TGT_NONE;
    end
    return t;
  endfunction

  logic [2:0] state_q, state_d;
  logic       phi2_prev_q;
  logic       phi2_armed_q;
  logic       rw_q, rw_d;
  logic [1:0] tgt_q, tgt_d;
  logic       rom_en_q, rom_en_d;
  logic       ram_en_q, ram_en_d;
  logic       io_en_q, io_en_d;
  logic       ram_we_q, ram_we_d;
  logic       io_we_q, io_we_d;
  logic [9:0] rom_a_q, rom_a_d;
  logic [5:0] ram_a_q, ram_a_d;
  logic [3:0] io_a_q, io_a_d;
  logic [7:0] ram_di_q, ram_di_d;
  logic [7:0] io_di_q, io_di_d;
  logic [7:0] dout_q, dout_d;
  logic       doe_q, doe_d;

  logic       rise_s;
  logic       fall_s;
  logic [1:0] dec_s;
  logic       rd_hit_s;
  logic [7:0] rd_data_s;
  logic [7:0] dout_idle_s;

  // A rise counts only after phi2 has been seen low since reset. This stops
  // a phi2 that is still high at reset release from starting a cycle.
  assign rise_s = phi2 & ~phi2_prev_q & phi2_armed_q;
  assign fall_s = ~phi2 & phi2_prev_q;
  assign dec_s  = decode_target(rs0_n, cs, a[6]);

`ifdef RRIOT_BUS_HOLD_EN
  assign dout_idle_s = dout_q;
`else
  assign dout_idle_s = 8'h00;
`endif

  // Read-return mux: ROM has priority over RAM, and RAM over IO.
  always_comb begin
    rd_hit_s  = 1'b0;
    rd_data_s = 8'h00;
    if (rom_oe) begin
      rd_hit_s  = 1'b1;
      rd_data_s = rom_do;
    end else if (ram_oe) begin
      rd_hit_s  = 1'b1;
      rd_data_s = ram_do;
    end else if (io_oe) begin
      rd_hit_s  = 1'b1;
      rd_data_s = io_do;
    end else begin
      rd_hit_s  = 1'b0;
      rd_data_s = 8'h00;
    end
  end

  // Next-state and next-output logic for the bus cycle sequencer.
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    tgt_d    = tgt_q;
    rom_en_d = rom_en_q;
    ram_en_d = ram_en_q;
    io_en_d  = io_en_q;
    ram_we_d = 1'b0;
    io_we_d  = 1'b0;
    rom_a_d  = rom_a_q;
    ram_a_d  = ram_a_q;
    io_a_d   = io_a_q;
    ram_di_d = ram_di_q;
    io_di_d  = io_di_q;
    doe_d    = 1'b0;
    dout_d   = dout_idle_s;

    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d  = ST_ADDR;
          rw_d     = rw;
          tgt_d    = dec_s;
          rom_en_d = (dec_s == TGT_ROM);
          ram_en_d = (dec_s == TGT_RAM);
          io_en_d  = (dec_s == TGT_IO);
          if (dec_s == TGT_ROM) begin
            rom_a_d = a;
          end else if (dec_s == TGT_RAM) begin
            ram_a_d = a[5:0];
          end else if (dec_s == TGT_IO) begin
            io_a_d = a[3:0];
          end else begin
            rom_a_d = rom_a_q;
          end
        end else begin
          // Clears the enable that was kept up through the write-strobe cycle.
          rom_en_d = 1'b0;
          ram_en_d = 1'b0;
          io_en_d  = 1'b0;
        end
      end
      ST_ADDR: begin
        if (fall_s) begin
          state_d  = ST_IDLE;
          rom_en_d = 1'b0;
          ram_en_d = 1'b0;
          io_en_d  = 1'b0;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fall_s) begin
          state_d  = ST_IDLE;
          rom_en_d = 1'b0;
          ram_en_d = 1'b0;
          io_en_d  = 1'b0;
        end else if (rw_q) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          state_d  = ST_IDLE;
          rom_en_d = 1'b0;
          ram_en_d = 1'b0;
          io_en_d  = 1'b0;
        end else if ((tgt_q != TGT_NONE) && rd_hit_s) begin
          doe_d  = 1'b1;
          dout_d = rd_data_s;
        end else begin
          doe_d  = 1'b0;
          dout_d = dout_idle_s;
        end
      end
      ST_WRITE: begin
        if (fall_s) begin
          // The enable stays up for the strobe cycle and drops in IDLE.
          state_d = ST_IDLE;
          if (tgt_q == TGT_RAM) begin
            ram_we_d = 1'b1;
            ram_di_d = di;
          end else if (tgt_q == TGT_IO) begin
            io_we_d = 1'b1;
            io_di_d = di;
          end else begin
            ram_we_d = 1'b0;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rom_en_d = 1'b0;
        ram_en_d = 1'b0;
        io_en_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared at once by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phi2_prev_q  <= 1'b0;
      phi2_armed_q <= 1'b0;
      rw_q         <= 1'b0;
      tgt_q        <= TGT_NONE;
      rom_en_q     <= 1'b0;
      ram_en_q     <= 1'b0;
      io_en_q      <= 1'b0;
      ram_we_q     <= 1'b0;
      io_we_q      <= 1'b0;
      rom_a_q      <= 10'h000;
      ram_a_q      <= 6'h00;
      io_a_q       <= 4'h0;
      ram_di_q     <= 8'h00;
      io_di_q      <= 8'h00;
      dout_q       <= 8'h00;
      doe_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phi2_prev_q  <= phi2;
      phi2_armed_q <= phi2_armed_q | ~phi2;
      rw_q         <= rw_d;
      tgt_q        <= tgt_d;
      rom_en_q     <= rom_en_d;
      ram_en_q     <= ram_en_d;
      io_en_q      <= io_en_d;
      ram_we_q     <= ram_we_d;
      io_we_q      <= io_we_d;
      rom_a_q      <= rom_a_d;
      ram_a_q      <= ram_a_d;
      io_a_q       <= io_a_d;
      ram_di_q     <= ram_di_d;
      io_di_q      <= io_di_d;
      dout_q       <= dout_d;
      doe_q        <= doe_d;
    end
  end

  assign rom_en = rom_en_q;
  assign rom_a  = rom_a_q;
  assign ram_en = ram_en_q;
  assign ram_we = ram_we_q;
  assign ram_a  = ram_a_q;
  assign ram_di = ram_di_q;
  assign io_en  = io_en_q;
  assign io_we  = io_we_q;
  assign io_a   = io_a_q;
  assign io_di  = io_di_q;
  assign dout   = dout_q;
  assign doe    = doe_q;

endmodule
